// File: rtl/io_capture_pkg.sv
// -----------------------------------------------------------------------------
// io_capture_pkg
// Shared definitions for the IO event capture block: Wishbone register word
// indices, CTRL/STATUS bit positions and the STATUS fill-level field layout.
// -----------------------------------------------------------------------------
package io_capture_pkg;

   // Register word index, taken from wbs_adr_i[4:2]
   typedef enum logic [2:0] {
      REG_CTRL     = 3'd0,
      REG_MASK     = 3'd1,
      REG_STATUS   = 3'd2,
      REG_HEAD_VAL = 3'd3,
      REG_HEAD_TS  = 3'd4,
      REG_RSVD5    = 3'd5,
      REG_RSVD6    = 3'd6,
      REG_RSVD7    = 3'd7
   } reg_idx_e;

   // CTRL bits
   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_CLR_BIT = 1;
   localparam int CTRL_IE_BIT  = 2;

   // STATUS bits
   localparam int STAT_EMPTY_BIT = 0;
   localparam int STAT_FULL_BIT  = 1;
   localparam int STAT_OVF_BIT   = 2;

   // STATUS fill-level field
   localparam int STAT_LEVEL_LSB = 8;
   localparam int STAT_LEVEL_W   = 8;

endpackage

// File: rtl/capture_fifo.sv
// -----------------------------------------------------------------------------
// capture_fifo
// Small synchronous FIFO holding captured {io value, timestamp} entries.
// The head entry is presented combinationally so firmware can inspect it
// without popping; an empty FIFO presents zero.
//
// Ports:
//   clk        in   clock
//   srst       in   synchronous active-high reset
//   push       in   write push_data (dropped when full unless popping too)
//   pop        in   remove head entry (ignored when empty)
//   clear      in   empty the FIFO; overrides a push in the same cycle
//   push_data  in   WIDTH-bit entry to write
//   head_data  out  current head entry, zero when empty
//   full       out  DEPTH entries stored
//   empty      out  no entries stored
//   level      out  number of stored entries
// -----------------------------------------------------------------------------
module capture_fifo #(
   parameter int WIDTH = 46,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         push_data,
   output logic [WIDTH-1:0]         head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_read;
   logic             do_write;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == (AW+1)'(DEPTH));
   assign level = count_reg;

   // A pop frees the slot a simultaneous push needs, so a full FIFO can
   // accept a push in the same cycle as a pop.
   assign do_read  = pop & ~empty;
   assign do_write = push & ~clear & (~full | do_read);

   // Head is read directly so it is visible without a pop.
   assign head_data = empty ? '0 : mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (srst || clear) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_write) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_read) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_write, do_read})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/io_event_capture.sv
// -----------------------------------------------------------------------------
// io_event_capture
// Synchronises io_in, detects changes on masked bits and timestamps each
// change into a small FIFO that firmware drains over Wishbone. irq flags a
// non-empty FIFO when enabled.
//
// Ports:
//   wb_clk_i        in   clock
//   wb_rst_i        in   synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i  in  Wishbone strobes
//   wbs_sel_i       in   byte enables for writes
//   wbs_adr_i       in   address, word index in [4:2]
//   wbs_dat_i       in   write data
//   wbs_ack_o       out  one-cycle acknowledge
//   wbs_dat_o       out  read data, valid while ack is high
//   io_in           in   asynchronous pad inputs
//   irq             out  level interrupt (IE & not empty), registered
// -----------------------------------------------------------------------------
module io_event_capture
   import io_capture_pkg::*;
#(
   parameter int BITS    = 30,
   parameter int DEPTH   = 4,
   parameter int TS_BITS = 16
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            wbs_cyc_i,
   input  logic            wbs_stb_i,
   input  logic            wbs_we_i,
   input  logic [3:0]      wbs_sel_i,
   input  logic [31:0]     wbs_adr_i,
   input  logic [31:0]     wbs_dat_i,
   output logic            wbs_ack_o,
   output logic [31:0]     wbs_dat_o,
   input  logic [BITS-1:0] io_in,
   output logic            irq
);

   localparam int          LVL_W      = $clog2(DEPTH) + 1;
   localparam int          ENTRY_W    = BITS + TS_BITS;
   localparam logic [31:0] MASK_VALID = (BITS >= 32) ? 32'hFFFF_FFFF
                                                     : 32'((64'd1 << BITS) - 64'd1);

   // Input path
   logic [BITS-1:0]    s1_reg;
   logic [BITS-1:0]    s2_reg;
   logic [BITS-1:0]    prev_reg;
   logic [BITS-1:0]    chg;

   // Register file
   logic               en_reg;
   logic               ie_reg;
   logic               ovf_reg;
   logic [31:0]        mask_reg;
   logic [31:0]        mask_next;
   logic [TS_BITS-1:0] ts_reg;
   logic               irq_reg;

   // Wishbone
   logic               ack_reg;
   logic [31:0]        dat_reg;
   logic [31:0]        rd_data;
   logic               wb_access;
   logic               wr_en;
   logic               rd_en;
   reg_idx_e           reg_idx;

   // Control strobes
   logic               ctrl_wr;
   logic               clr_req;
   logic               pop_req;
   logic               push_req;
   logic               ovf_set;
   logic               ovf_clr;

   // FIFO
   logic [ENTRY_W-1:0] head_data;
   logic [BITS-1:0]    head_val;
   logic [TS_BITS-1:0] head_ts;
   logic               fifo_full;
   logic               fifo_empty;
   logic [LVL_W-1:0]   fifo_level;

   logic               unused_adr;
   assign unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

   // An access is taken only while ack is low, so a held strobe is
   // acknowledged on alternate cycles and every side effect lands on the
   // edge that raises ack.
   assign wb_access = wbs_cyc_i & wbs_stb_i & ~ack_reg;
   assign wr_en     = wb_access & wbs_we_i;
   assign rd_en     = wb_access & ~wbs_we_i;
   assign reg_idx   = reg_idx_e'(wbs_adr_i[4:2]);

   assign ctrl_wr = wr_en & (reg_idx == REG_CTRL) & wbs_sel_i[0];
   assign clr_req = ctrl_wr & wbs_dat_i[CTRL_CLR_BIT];
   assign ovf_clr = wr_en & (reg_idx == REG_STATUS) & wbs_sel_i[0] & wbs_dat_i[STAT_OVF_BIT];
   assign pop_req = rd_en & (reg_idx == REG_HEAD_TS);

   // prev follows s2 every cycle regardless of EN, so enabling capture
   // never sees a stale comparison value.
   assign chg      = (s2_reg ^ prev_reg) & mask_reg[BITS-1:0];
   assign push_req = en_reg & (|chg);

   // A full FIFO only overflows if no pop frees a slot and no clear discards
   // the push anyway.
   assign ovf_set = push_req & fifo_full & ~pop_req & ~clr_req;

   // MASK byte lanes
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_mask_lane
         assign mask_next[gi*8 +: 8] =
            (wr_en && (reg_idx == REG_MASK) && wbs_sel_i[gi]) ? wbs_dat_i[gi*8 +: 8]
                                                               : mask_reg[gi*8 +: 8];
      end
   endgenerate

   capture_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (wb_clk_i),
      .srst      (wb_rst_i),
      .push      (push_req),
      .pop       (pop_req),
      .clear     (clr_req),
      .push_data ({s2_reg, ts_reg}),
      .head_data (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign head_val = head_data[ENTRY_W-1:TS_BITS];
   assign head_ts  = head_data[TS_BITS-1:0];

   always_comb begin
      rd_data = '0;
      case (reg_idx)
         REG_CTRL: begin
            rd_data[CTRL_EN_BIT] = en_reg;
            rd_data[CTRL_IE_BIT] = ie_reg;
         end
         REG_MASK: begin
            rd_data = mask_reg;
         end
         REG_STATUS: begin
            rd_data[STAT_EMPTY_BIT] = fifo_empty;
            rd_data[STAT_FULL_BIT]  = fifo_full;
            rd_data[STAT_OVF_BIT]   = ovf_reg;
            rd_data[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(fifo_level);
         end
         REG_HEAD_VAL: begin
            rd_data = 32'(head_val);
         end
         REG_HEAD_TS: begin
            rd_data = 32'(head_ts);
         end
         default: begin
            rd_data = '0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         s1_reg   <= '0;
         s2_reg   <= '0;
         prev_reg <= '0;
         en_reg   <= 1'b0;
         ie_reg   <= 1'b0;
         ovf_reg  <= 1'b0;
         mask_reg <= '0;
         ts_reg   <= '0;
         irq_reg  <= 1'b0;
         ack_reg  <= 1'b0;
         dat_reg  <= '0;
      end else begin
         s1_reg   <= io_in;
         s2_reg   <= s1_reg;
         prev_reg <= s2_reg;

         ack_reg  <= wb_access;
         dat_reg  <= rd_en ? rd_data : '0;

         if (ctrl_wr) begin
            en_reg <= wbs_dat_i[CTRL_EN_BIT];
            ie_reg <= wbs_dat_i[CTRL_IE_BIT];
         end
         mask_reg <= mask_next & MASK_VALID;

         if (clr_req) begin
            ts_reg <= '0;
         end else if (en_reg) begin
            ts_reg <= ts_reg + TS_BITS'(1);
         end

         // A new overflow wins over a simultaneous clear so it is not lost.
         if (ovf_set) begin
            ovf_reg <= 1'b1;
         end else if (ovf_clr) begin
            ovf_reg <= 1'b0;
         end

         irq_reg <= ie_reg & ~fifo_empty;
      end
   end

   assign wbs_ack_o = ack_reg;
   assign wbs_dat_o = dat_reg;
   assign irq       = irq_reg;

endmodule

// File: tb/tb_io_event_capture.sv
// -----------------------------------------------------------------------------
// tb_io_event_capture
// Self-checking bench: a reference model at each rising edge predicts FIFO
// contents, registers, ack and irq; expected read data is queued at access
// acceptance and compared by a monitor whenever the DUT acknowledges.
// -----------------------------------------------------------------------------
module tb_io_event_capture;

   localparam int BITS    = 30;
   localparam int DEPTH   = 4;
   localparam int TS_BITS = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            cyc;
   logic            stb;
   logic            we;
   logic [3:0]      sel;
   logic [31:0]     adr;
   logic [31:0]     dat_i;
   logic            ack;
   logic [31:0]     dat_o;
   logic [BITS-1:0] io;
   logic            irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   io_event_capture #(
      .BITS    (BITS),
      .DEPTH   (DEPTH),
      .TS_BITS (TS_BITS)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (dat_i),
      .wbs_ack_o (ack),
      .wbs_dat_o (dat_o),
      .io_in     (io),
      .irq       (irq)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit              m_en = 0, m_ie = 0, m_ovf = 0, m_ack = 0, m_irq = 0;
   logic [31:0]     m_mask = '0;
   int unsigned     m_ts = 0;
   logic [BITS-1:0] h1 = '0, h2 = '0, h3 = '0;   // io sampled 1, 2, 3 edges ago
   logic [BITS-1:0] q_val[$];
   int unsigned     q_ts[$];
   logic [31:0]     exp_dat[$];
   bit              exp_rd[$];

   bit              mt_acc, mt_clr, mt_pop, mt_push, mt_irq;
   int              mt_r;
   int              mt_lvl;
   logic [31:0]     mt_rd;

   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_en = 0; m_ie = 0; m_ovf = 0; m_ack = 0; m_irq = 0;
         m_mask = '0; m_ts = 0;
         h1 = '0; h2 = '0; h3 = '0;
         q_val.delete(); q_ts.delete();
      end else begin
         mt_acc = cyc && stb && !m_ack;
         mt_r   = int'(adr[4:2]);
         mt_lvl = q_val.size();
         mt_irq = m_ie && (mt_lvl != 0);
         if (mt_acc) begin
            mt_rd = '0;
            if (!we) begin
               case (mt_r)
                  0: mt_rd = {29'd0, m_ie, 1'b0, m_en};
                  1: mt_rd = m_mask;
                  2: mt_rd = {16'd0, 8'(mt_lvl), 5'd0, m_ovf, mt_lvl == DEPTH, mt_lvl == 0};
                  3: mt_rd = (mt_lvl == 0) ? 32'd0 : 32'(q_val[0]);
                  4: mt_rd = (mt_lvl == 0) ? 32'd0 : q_ts[0];
                  default: mt_rd = '0;
               endcase
            end
            exp_dat.push_back(mt_rd);
            exp_rd.push_back(!we);
         end
         mt_clr  = mt_acc && we && mt_r == 0 && sel[0] && dat_i[1];
         mt_pop  = mt_acc && !we && mt_r == 4;
         mt_push = m_en && (((h2 ^ h3) & m_mask[BITS-1:0]) != '0);
         if (mt_acc && we && mt_r == 2 && sel[0] && dat_i[2]) m_ovf = 0;
         if (mt_clr) begin
            q_val.delete(); q_ts.delete();
         end else begin
            if (mt_pop && q_val.size() > 0) begin
               void'(q_val.pop_front());
               void'(q_ts.pop_front());
            end
            if (mt_push) begin
               if (q_val.size() < DEPTH) begin
                  q_val.push_back(h2);
                  q_ts.push_back(m_ts);
               end else begin
                  m_ovf = 1;
               end
            end
         end
         if (mt_clr) m_ts = 0;
         else if (m_en) m_ts = (m_ts + 1) % (1 << TS_BITS);
         if (mt_acc && we && mt_r == 0 && sel[0]) begin
            m_en = dat_i[0];
            m_ie = dat_i[2];
         end
         if (mt_acc && we && mt_r == 1) begin
            for (int b = 0; b < 4; b++) if (sel[b]) m_mask[8*b +: 8] = dat_i[8*b +: 8];
            m_mask = m_mask & ((32'd1 << BITS) - 32'd1);
         end
         h3 = h2; h2 = h1; h1 = io;
         m_irq = mt_irq;
         m_ack = mt_acc;
      end
   end

   // ---------------- monitor ----------------
   initial forever begin
      @(negedge clk);
      chk("ack_timing", {31'd0, ack}, {31'd0, m_ack});
      chk("irq_level", {31'd0, irq}, {31'd0, m_irq});
      if (ack) begin
         if (exp_dat.size() == 0) begin
            chk("unexpected_ack", 32'd1, 32'd0);
         end else begin
            logic [31:0] e;
            bit          r;
            e = exp_dat.pop_front();
            r = exp_rd.pop_front();
            if (r) chk("read_data", dat_o, e);
         end
      end
   end

   // ---------------- Wishbone driver (call at a falling edge) ----------------
   task automatic wb_access(input bit w, input int idx, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd);
      int n;
      cyc   = 1'b1;
      stb   = 1'b1;
      we    = w;
      adr   = ($urandom() & ~32'h1C) | (32'(idx) << 2);
      dat_i = d;
      sel   = s;
      n     = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack && n < 20);
      chk("wb_ack_seen", {31'd0, ack}, 32'd1);
      rd  = dat_o;
      cyc = 1'b0;
      stb = 1'b0;
      we  = 1'b0;
   endtask

   task automatic wb_rd(input int idx, output logic [31:0] d);
      wb_access(1'b0, idx, 32'd0, 4'hF, d);
   endtask

   task automatic wb_wr(input int idx, input logic [31:0] d);
      logic [31:0] dummy;
      wb_access(1'b1, idx, d, 4'hF, dummy);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] rd, t1, t2, t3;
      int          n;
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      sel = '0; adr = '0; dat_i = '0; io = '0;
      repeat (3) @(negedge clk);
      chk("rst_dat_o", dat_o, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Reset register values
      wb_rd(0, rd); chk("rst_ctrl", rd, 32'd0);
      wb_rd(1, rd); chk("rst_mask", rd, 32'd0);
      wb_rd(2, rd); chk("rst_status", rd, 32'h1);
      wb_rd(4, rd); chk("rst_head_ts", rd, 32'd0);
      wb_rd(3, rd); chk("rst_head_val", rd, 32'd0);

      // Single masked event and its latency
      wb_wr(1, 32'h1);
      wb_wr(0, 32'h5);
      repeat (3) @(negedge clk);
      io[0] = 1'b1;
      @(posedge clk); @(posedge clk); @(posedge clk); #1;
      chk("irq_edge_n2", {31'd0, irq}, 32'd0);
      @(posedge clk); #1;
      chk("irq_edge_n3", {31'd0, irq}, 32'd1);
      @(negedge clk);
      wb_rd(2, rd); chk("one_status", rd, 32'h100);
      wb_rd(3, rd); chk("one_head_val", rd, 32'h1);
      wb_rd(4, rd);
      wb_rd(2, rd); chk("one_popped_status", rd, 32'h1);
      repeat (2) @(negedge clk);
      chk("irq_after_pop", {31'd0, irq}, 32'd0);

      // Unmasked bit change
      io[1] = 1'b1;
      repeat (6) @(negedge clk);
      wb_rd(2, rd); chk("unmasked_status", rd, 32'h1);

      // Overflow with 5 events, spaced 7 cycles
      wb_wr(0, 32'h7);
      for (int i = 0; i < 5; i++) begin
         io[0] = ~io[0];
         repeat (7) @(negedge clk);
      end
      wb_rd(2, rd); chk("ovf_status", rd, 32'h406);
      wb_wr(2, 32'h4);
      wb_rd(2, rd); chk("ovf_w1c_status", rd, 32'h402);

      // Pop coinciding with a push while full
      io[0] = ~io[0];
      @(negedge clk); @(negedge clk);
      wb_rd(4, t1);
      wb_rd(2, rd); chk("full_pushpop_status", rd, 32'h402);
      wb_rd(4, t2);
      wb_rd(4, t3);
      chk("ts_order", {31'd0, t2 < t3}, 32'd1);
      chk("ts_delta_12", t2 - t1, 32'd7);
      chk("ts_delta_23", t3 - t2, 32'd7);

      // CLR together with a push
      io[0] = ~io[0];
      @(negedge clk); @(negedge clk);
      wb_wr(0, 32'h7);
      io[0] = ~io[0];
      wb_rd(2, rd); chk("clr_status", rd, 32'h1);
      repeat (2) @(negedge clk);
      wb_rd(4, rd); chk("clr_ts_restart", rd, 32'd2);

      // Held strobe: acks on alternate cycles
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8; sel = 4'hF;
      n = 0;
      repeat (6) begin
         @(negedge clk);
         if (ack) n++;
      end
      cyc = 1'b0; stb = 1'b0;
      chk("held_acks", 32'(n), 32'd3);
      @(negedge clk);

      // Randomised traffic
      wb_wr(1, 32'hFF);
      wb_wr(0, 32'h5);
      for (int it = 0; it < 300; it++) begin
         int          k;
         int          idx;
         bit          w;
         logic [31:0] d;
         k = $urandom_range(0, 9);
         if (k < 4) begin
            io = io ^ (BITS'(1) << $urandom_range(0, 9));
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end else begin
            idx = $urandom_range(0, 7);
            w   = ($urandom_range(0, 2) == 0);
            d   = $urandom();
            if (idx == 0) begin
               d[0] = ($urandom_range(0, 3) != 0);
               d[1] = ($urandom_range(0, 7) == 0);
            end
            wb_access(w, idx, d, 4'($urandom_range(0, 15)), rd);
         end
      end

      // Reset during an ack-pending cycle
      wb_wr(1, 32'h3FFF_FFFF);
      wb_wr(0, 32'h5);
      io = ~io;
      repeat (5) @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; rst = 1'b1;
      @(negedge clk);
      chk("rst_ack_suppressed", {31'd0, ack}, 32'd0);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      wb_rd(0, rd); chk("post_rst_ctrl", rd, 32'd0);
      wb_rd(1, rd); chk("post_rst_mask", rd, 32'd0);
      wb_rd(2, rd); chk("post_rst_status", rd, 32'h1);
      wb_rd(4, rd); chk("post_rst_head_ts", rd, 32'd0);
      chk("post_rst_irq", {31'd0, irq}, 32'd0);
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
